fp16_invsqrt_nr_ctrl: RTL and testbench



---
 rtl/fp16_pkg.sv | 21 ++
 rtl/fp16_classify.sv | 20 ++
 rtl/fp16_invsqrt_nr_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fp16_invsqrt_nr_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 constants and controller state encoding for the inverse-sqrt
// Newton-Raphson sequencer.
package fp16_pkg;

    localparam logic [15:0] FP16_ONE_HALF      = 16'h3800;
    localparam logic [15:0] FP16_THREE_HALVES  = 16'h3E00;
    localparam logic [15:0] FP16_INVSQRT_MAGIC = 16'h5A00;
    localparam logic [15:0] FP16_QNAN          = 16'h7E00;
    localparam logic [15:0] FP16_POS_INF       = 16'h7C00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_XHALF,
        S_SQ,
        S_TERM,
        S_SUB,
        S_UPD,
        S_DONE
    } state_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational fp16 operand classifier: zero, infinity, NaN and sign flags.
module fp16_classify (
    input  logic [15:0] value,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        sign
);

    logic exp_ones;
    logic man_zero;

    assign exp_ones = &value[14:10];
    assign man_zero = (value[9:0] == 10'h000);
    assign is_zero  = (value[14:0] == 15'h0000);
    assign is_inf   = exp_ones && man_zero;
    assign is_nan   = exp_ones && !man_zero;
    assign sign     = value[15];

endmodule

// File: rtl/fp16_invsqrt_nr_ctrl.sv
// fp16 1/sqrt(x) sequencer driving a shared external multiplier and adder.
// Optional perf counters: define FP16_INVSQRT_NR_CTRL_PERF_EN.
module fp16_invsqrt_nr_ctrl
    import fp16_pkg::*;
#(
    parameter int unsigned NR_ITERS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
`ifdef FP16_INVSQRT_NR_CTRL_PERF_EN
    output logic [15:0] perf_ops,
    output logic [15:0] perf_special,
`endif
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [15:0] mul_res,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_res,
    output logic        busy
);

    if (NR_ITERS < 1 || NR_ITERS > 3) begin : g_bad_iters
        $error("fp16_invsqrt_nr_ctrl: NR_ITERS must be in 1..3");
    end

    localparam logic [1:0] LAST_ITER = 2'(NR_ITERS - 1);

    state_t      state, state_n;
    logic [15:0] x_r, xh_r, y_r, t_r, out_r;
    logic [1:0]  iter_r;
    logic        is_zero, is_inf, is_nan, sign;
    logic        special;
    logic [15:0] special_val;
    logic        accept;
    logic        last_iter;

    fp16_classify u_classify (
        .value   (in_data),
        .is_zero (is_zero),
        .is_inf  (is_inf),
        .is_nan  (is_nan),
        .sign    (sign)
    );

    // Negative nonzero (including -inf) is invalid; -0 is treated like +0.
    always_comb begin
        special     = 1'b1;
        special_val = '0;
        if (is_nan || (sign && !is_zero)) special_val = FP16_QNAN;
        else if (is_inf)                  special_val = '0;
        else if (is_zero)                 special_val = FP16_POS_INF;
        else                              special     = 1'b0;
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_data  = out_r;
    assign accept    = in_valid && in_ready;
    assign last_iter = (iter_r == LAST_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        mul_a   = '0;
        mul_b   = '0;
        add_a   = '0;
        add_b   = '0;
        case (state)
            S_IDLE:  if (accept) state_n = special ? S_DONE : S_XHALF;
            S_XHALF: begin
                mul_a   = x_r;
                mul_b   = FP16_ONE_HALF;
                state_n = S_SQ;
            end
            S_SQ: begin
                mul_a   = y_r;
                mul_b   = y_r;
                state_n = S_TERM;
            end
            S_TERM: begin
                mul_a   = xh_r;
                mul_b   = t_r;
                state_n = S_SUB;
            end
            S_SUB: begin
                add_a   = FP16_THREE_HALVES;
                add_b   = {~t_r[15], t_r[14:0]};
                state_n = S_UPD;
            end
            S_UPD: begin
                mul_a   = y_r;
                mul_b   = t_r;
                state_n = last_iter ? S_DONE : S_SQ;
            end
            S_DONE:  if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= '0;
            xh_r   <= '0;
            y_r    <= '0;
            t_r    <= '0;
            out_r  <= '0;
            iter_r <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    x_r    <= in_data;
                    iter_r <= '0;
                    if (special) out_r <= special_val;
                    else         y_r   <= FP16_INVSQRT_MAGIC - {1'b0, in_data[15:1]};
                end
                S_XHALF: xh_r <= mul_res;
                S_SQ:    t_r  <= mul_res;
                S_TERM:  t_r  <= mul_res;
                S_SUB:   t_r  <= add_res;
                S_UPD: begin
                    y_r <= mul_res;
                    if (last_iter) out_r  <= mul_res;
                    else           iter_r <= iter_r + 2'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef FP16_INVSQRT_NR_CTRL_PERF_EN
    logic special_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            special_r    <= 1'b0;
            perf_ops     <= '0;
            perf_special <= '0;
        end else begin
            if (accept) special_r <= special;
            if (out_valid && out_ready) begin
                if (special_r) begin
                    if (perf_special != 16'hFFFF) perf_special <= perf_special + 16'd1;
                end else begin
                    if (perf_ops != 16'hFFFF) perf_ops <= perf_ops + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp16_invsqrt_nr_ctrl.sv
// Directed self-checking bench: two controllers (NR_ITERS=1 and 3) share the
// input stimulus; each has its own behavioural fp16 multiplier/adder.
module tb_fp16_invsqrt_nr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        add_nan = 1'b0;

    logic        in_ready, out_valid, busy;
    logic [15:0] out_data, mul_a, mul_b, mul_res, add_a, add_b, add_res;
    logic        in_ready3, out_valid3, busy3;
    logic [15:0] out_data3, mul_a3, mul_b3, mul_res3, add_a3, add_b3, add_res3;
`ifdef FP16_INVSQRT_NR_CTRL_PERF_EN
    logic [15:0] perf_ops, perf_special, perf_ops3, perf_special3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Truncating fp16 multiply, normal operands only.
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        int          e;
        if (&a[14:10] || &b[14:10]) return 16'h7E00;
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {a[15] ^ b[15], 15'h0000};
        p = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) return {a[15] ^ b[15], 5'(e + 1), p[20:11]};
        return {a[15] ^ b[15], 5'(e), p[19:10]};
    endfunction

    // Truncating fp16 add, normal operands only.
    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] hi, lo;
        logic [13:0] mh, ml;
        logic [14:0] sum;
        int          e, sh;
        if (&a[14:10] || &b[14:10]) return 16'h7E00;
        if (a[14:0] >= b[14:0]) begin hi = a; lo = b; end
        else begin hi = b; lo = a; end
        if (lo[14:0] == 15'h0) return hi;
        mh  = {1'b1, hi[9:0], 3'b000};
        ml  = {1'b1, lo[9:0], 3'b000};
        sh  = int'(hi[14:10]) - int'(lo[14:10]);
        ml  = (sh > 13) ? 14'h0 : (ml >> sh);
        sum = (hi[15] == lo[15]) ? ({1'b0, mh} + {1'b0, ml}) : ({1'b0, mh} - {1'b0, ml});
        e   = int'(hi[14:10]);
        if (sum == 15'h0) return 16'h0000;
        if (sum[14]) begin sum = sum >> 1; e++; end
        for (int i = 0; i < 14; i++) if (!sum[13]) begin sum = sum << 1; e--; end
        return {hi[15], 5'(e), sum[12:3]};
    endfunction

    assign mul_res  = fmul(mul_a, mul_b);
    assign add_res  = add_nan ? 16'h7E00 : fadd(add_a, add_b);
    assign mul_res3 = fmul(mul_a3, mul_b3);
    assign add_res3 = fadd(add_a3, add_b3);

    fp16_invsqrt_nr_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef FP16_INVSQRT_NR_CTRL_PERF_EN
        .perf_ops(perf_ops), .perf_special(perf_special),
`endif
        .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
        .add_a(add_a), .add_b(add_b), .add_res(add_res),
        .busy(busy)
    );

    fp16_invsqrt_nr_ctrl #(.NR_ITERS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
`ifdef FP16_INVSQRT_NR_CTRL_PERF_EN
        .perf_ops(perf_ops3), .perf_special(perf_special3),
`endif
        .mul_a(mul_a3), .mul_b(mul_b3), .mul_res(mul_res3),
        .add_a(add_a3), .add_b(add_b3), .add_res(add_res3),
        .busy(busy3)
    );

    // Presents x for one accepting edge; returns at the falling edge right after it.
    task automatic send(input logic [15:0] x);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready x=%h: in_ready=%b expected 1", x, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((busy || busy3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || busy3) begin
            errors++;
            $display("FAIL drain_timeout: busy=%b busy3=%b expected 0 0", busy, busy3);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100 || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/valid=%b data=%h expected 100 0000",
                     {in_ready, busy, out_valid}, out_data);
        end
        checks++;
        if ({mul_a, mul_b, add_a, add_b} !== 64'h0) begin
            errors++;
            $display("FAIL reset_fpu: ops=%h expected 0", {mul_a, mul_b, add_a, add_b});
        end
        checks++;
        if ({in_ready3, busy3, out_valid3} !== 3'b100 || out_data3 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ctrl3: ready/busy/valid=%b data=%h expected 100 0000",
                     {in_ready3, busy3, out_valid3}, out_data3);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal(input logic [15:0] x, input logic [15:0] e1,
                               input logic [15:0] e3, input bit chk3);
        send(x);
        for (int j = 0; j <= 13; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'(j >= 5) || out_valid3 !== 1'(j >= 13)) begin
                errors++;
                $display("FAIL latency x=%h j=%0d: valid=%b valid3=%b expected %b %b",
                         x, j, out_valid, out_valid3, j >= 5, j >= 13);
            end
        end
        checks++;
        if (out_data !== e1) begin
            errors++;
            $display("FAIL result x=%h: got %h expected %h", x, out_data, e1);
        end
        if (chk3) begin
            checks++;
            if (out_data3 !== e3) begin
                errors++;
                $display("FAIL result3 x=%h: got %h expected %h", x, out_data3, e3);
            end
        end
        drain();
    endtask

    task automatic test_operands();
        logic [63:0] exp_ops [6];
        exp_ops[0] = {16'h4400, 16'h3800, 16'h0000, 16'h0000};
        exp_ops[1] = {16'h3800, 16'h3800, 16'h0000, 16'h0000};
        exp_ops[2] = {16'h4000, 16'h3400, 16'h0000, 16'h0000};
        exp_ops[3] = {16'h0000, 16'h0000, 16'h3E00, 16'hB800};
        exp_ops[4] = {16'h3800, 16'h3C00, 16'h0000, 16'h0000};
        exp_ops[5] = 64'h0;
        send(16'h4400);
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if ({mul_a, mul_b, add_a, add_b} !== exp_ops[j]) begin
                errors++;
                $display("FAIL operands j=%0d: got %h expected %h", j,
                         {mul_a, mul_b, add_a, add_b}, exp_ops[j]);
            end
        end
        checks++;
        if (out_data !== 16'h3800 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL operands_result: valid=%b data=%h expected 1 3800", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_special();
        logic [31:0] vec [6];
        vec[0] = {16'h0000, 16'h7C00};
        vec[1] = {16'h8000, 16'h7C00};
        vec[2] = {16'hBC00, 16'h7E00};
        vec[3] = {16'h7C00, 16'h0000};
        vec[4] = {16'h7E00, 16'h7E00};
        vec[5] = {16'hFC00, 16'h7E00};
        for (int i = 0; i < 6; i++) begin
            send(vec[i][31:16]);
            for (int j = 0; j < 2; j++) begin
                if (j > 0) @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_data !== vec[i][15:0] ||
                    out_valid3 !== 1'b1 || out_data3 !== vec[i][15:0]) begin
                    errors++;
                    $display("FAIL special x=%h j=%0d: valid=%b%b data=%h/%h expected 11 %h",
                             vec[i][31:16], j, out_valid, out_valid3, out_data, out_data3,
                             vec[i][15:0]);
                end
                checks++;
                if ({mul_a, mul_b, add_a, add_b, mul_a3, mul_b3, add_a3, add_b3} !== 128'h0) begin
                    errors++;
                    $display("FAIL special_fpu x=%h: ops=%h/%h expected 0", vec[i][31:16],
                             {mul_a, mul_b, add_a, add_b}, {mul_a3, mul_b3, add_a3, add_b3});
                end
            end
            drain();
        end
    endtask

    task automatic test_back_pressure();
        send(16'h4400);
        repeat (5) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h3800 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold k=%0d: valid=%b data=%h ready=%b expected 1 3800 0",
                         k, out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_no_accept: busy=%b ready=%b expected 0 1", busy, in_ready);
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        send(16'h4400);
        repeat (2) @(negedge clk);
        checks++;
        if ({mul_a, mul_b} !== {16'h4000, 16'h3400}) begin
            errors++;
            $display("FAIL mid_term: mul=%h expected 40003400", {mul_a, mul_b});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, in_ready} !== 3'b001 || out_data !== 16'h0000 ||
            {mul_a, mul_b, add_a, add_b} !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset: busy/valid/ready=%b data=%h ops=%h expected 001 0000 0",
                     {busy, out_valid, in_ready}, out_data, {mul_a, mul_b, add_a, add_b});
        end
        checks++;
        if ({busy3, out_valid3, in_ready3} !== 3'b001 || out_data3 !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset3: busy/valid/ready=%b data=%h expected 001 0000",
                     {busy3, out_valid3, in_ready3}, out_data3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_normal(16'h4400, 16'h3800, 16'h3800, 1'b1);
    endtask

    task automatic test_nan_propagation();
        add_nan = 1'b1;
        send(16'h4400);
        repeat (4) @(negedge clk);
        checks++;
        if ({mul_a, mul_b} !== {16'h3800, 16'h7E00}) begin
            errors++;
            $display("FAIL nan_upd_operands: mul=%h expected 38007E00", {mul_a, mul_b});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h7E00) begin
            errors++;
            $display("FAIL nan_result: valid=%b data=%h expected 1 7E00", out_valid, out_data);
        end
        add_nan = 1'b0;
        drain();
    endtask

`ifdef FP16_INVSQRT_NR_CTRL_PERF_EN
    task automatic test_perf();
        test_reset();
        test_normal(16'h4400, 16'h3800, 16'h3800, 1'b1);
        test_normal(16'h3C00, 16'h3C00, 16'h3C00, 1'b1);
        send(16'h0000);
        drain();
        test_normal(16'h4C00, 16'h3400, 16'h3400, 1'b1);
        send(16'hBC00);
        drain();
        checks++;
        if (perf_ops !== 16'd3 || perf_special !== 16'd2) begin
            errors++;
            $display("FAIL perf_counts: ops=%0d special=%0d expected 3 2", perf_ops, perf_special);
        end
        force dut.perf_ops = 16'hFFFF;
        @(negedge clk);
        release dut.perf_ops;
        test_normal(16'h4400, 16'h3800, 16'h3800, 1'b0);
        checks++;
        if (perf_ops !== 16'hFFFF) begin
            errors++;
            $display("FAIL perf_saturate: ops=%h expected FFFF", perf_ops);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_operands();
        test_normal(16'h3C00, 16'h3C00, 16'h3C00, 1'b1);
        test_normal(16'h4C00, 16'h3400, 16'h3400, 1'b1);
        test_normal(16'h4200, 16'h3892, 16'h0000, 1'b0);
        test_special();
        test_back_pressure();
        test_reset_mid();
        test_nan_propagation();
`ifdef FP16_INVSQRT_NR_CTRL_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
